parking_counter: RTL and testbench

PARKING_COUNTER -- requirements
Module: parking_counter

---
 rtl/parking_counter.sv | 125 ++++++++++++
 tb/tb_parking_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/parking_counter.sv
// Parking-lot occupancy counter with sticky over/underflow flags and a
// double-dabble converter that drives two BCD display digits from the count.
module parking_counter #(
    parameter int CAPACITY = 99,
    parameter int W        = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         incr,
    input  logic         decr,
    input  logic         clr_err,
    output logic [W-1:0] count,
    output logic [W-1:0] free,
    output logic         full,
    output logic         empty,
    output logic         ovf_err,
    output logic         unf_err,
    output logic [3:0]   bcd_tens,
    output logic [3:0]   bcd_ones,
    output logic         bcd_valid
);

    localparam int            SW   = W + 8;
    localparam logic [W-1:0]  CAP  = W'(CAPACITY);
    localparam logic [W-1:0]  ONE  = W'(1);
    localparam logic [2:0]    LAST = 3'(W - 1);

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_e;

    conv_state_e   state_q;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  snap_q;
    logic [SW-1:0] sr_q, sr_d;
    logic [2:0]    iter_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [3:0]    tens_q, ones_q;
    logic          valid_q;
    logic          full_w, empty_w;
    logic          inc_only, dec_only;

    // One double-dabble step: correct each BCD nibble, then shift left.
    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        if (t[SW-1:SW-4] >= 4'd5) t[SW-1:SW-4] = t[SW-1:SW-4] + 4'd3;
        if (t[SW-5:SW-8] >= 4'd5) t[SW-5:SW-8] = t[SW-5:SW-8] + 4'd3;
        return t << 1;
    endfunction

    always_comb begin
        full_w   = (count_q == CAP);
        empty_w  = (count_q == '0);
        inc_only = incr & ~decr;
        dec_only = decr & ~incr;

        count_d = count_q;
        if (inc_only && !full_w)  count_d = count_q + ONE;
        if (dec_only && !empty_w) count_d = count_q - ONE;

        // A simultaneous error event beats the clear.
        ovf_d = (inc_only & full_w)  | (ovf_q & ~clr_err);
        unf_d = (dec_only & empty_w) | (unf_q & ~clr_err);

        sr_d = dabble(sr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            snap_q  <= '0;
            sr_q    <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b1;
            state_q <= CONV_IDLE;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;

            // Any count change, even mid-conversion, restarts from a fresh snapshot.
            if (count_q != snap_q) begin
                snap_q  <= count_q;
                sr_q    <= {8'b0, count_q};
                iter_q  <= '0;
                valid_q <= 1'b0;
                state_q <= CONV_SHIFT;
            end else begin
                case (state_q)
                    CONV_IDLE: ;
                    CONV_SHIFT: begin
                        sr_q <= sr_d;
                        if (iter_q == LAST) begin
                            tens_q  <= sr_d[SW-1:SW-4];
                            ones_q  <= sr_d[SW-5:SW-8];
                            valid_q <= 1'b1;
                            state_q <= CONV_IDLE;
                        end else begin
                            iter_q <= iter_q + 3'd1;
                        end
                    end
                    default: state_q <= CONV_IDLE;
                endcase
            end
        end
    end

    assign count     = count_q;
    assign free      = CAP - count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_parking_counter.sv
// Directed bench for parking_counter: a vector table for counter/flag
// behaviour plus hand sequences for the multi-cycle BCD converter cases.
module tb_parking_counter;

    logic       clk = 1'b0;
    logic       rst, incr, decr, clr_err;
    logic [6:0] count, free;
    logic       full, empty, ovf_err, unf_err, bcd_valid;
    logic [3:0] bcd_tens, bcd_ones;

    int nvec  = 0;
    int nmiss = 0;

    parking_counter #(.CAPACITY(99), .W(7)) dut (
        .clk(clk), .rst(rst), .incr(incr), .decr(decr), .clr_err(clr_err),
        .count(count), .free(free), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, i, d, c;
        logic [6:0] e_count;
        logic       e_ovf, e_unf, e_full, e_empty;
        logic [6:0] e_free;
    } vec_t;

    vec_t tbl[12];

    task automatic step(input logic r, input logic i, input logic d, input logic c);
        rst = r; incr = i; decr = d; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmiss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_digits(input string name, input int t, input int o, input int v);
        chk({name, " tens"},  int'(bcd_tens),  t);
        chk({name, " ones"},  int'(bcd_ones),  o);
        chk({name, " valid"}, int'(bcd_valid), v);
    endtask

    initial begin
        rst = 1'b0; incr = 1'b0; decr = 1'b0; clr_err = 1'b0;

        //            r     i     d     c     count ovf   unf   full  empty free
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd99};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd99};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd98};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd97};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'd97};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd98};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd98};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd99};

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst count", int'(count), 0);
        chk("rst free",  int'(free), 99);
        chk("rst full",  int'(full), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst ovf",   int'(ovf_err), 0);
        chk("rst unf",   int'(unf_err), 0);
        chk_digits("rst", 0, 0, 1);

        // One incr after reset: digits 0/1 valid eight edges after the count change
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("inc1 count", int'(count), 1);
        chk("inc1 empty", int'(empty), 0);
        for (int n = 1; n <= 7; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk_digits($sformatf("inc1 edge+%0d", n), 0, 0, 0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_digits("inc1 edge+8", 0, 1, 1);

        // Counter / flag vector table
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].r, tbl[k].i, tbl[k].d, tbl[k].c);
            nvec++;
            if ({count, ovf_err, unf_err, full, empty, free} !==
                {tbl[k].e_count, tbl[k].e_ovf, tbl[k].e_unf, tbl[k].e_full, tbl[k].e_empty, tbl[k].e_free}) begin
                nmiss++;
                $display("FAIL vec%0d: got count=%0d ovf=%0b unf=%0b full=%0b empty=%0b free=%0d, expected count=%0d ovf=%0b unf=%0b full=%0b empty=%0b free=%0d",
                         k, count, ovf_err, unf_err, full, empty, free,
                         tbl[k].e_count, tbl[k].e_ovf, tbl[k].e_unf, tbl[k].e_full, tbl[k].e_empty, tbl[k].e_free);
            end
        end

        // incr+decr together at count 5: no change, no conversion
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        chk_digits("five settled", 0, 5, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("both count", int'(count), 5);
        chk("both errs", int'({ovf_err, unf_err}), 0);
        idle(2);
        chk_digits("both no conv", 0, 5, 1);

        // 9 -> 10, then 11 mid-conversion: restart, 1/0 never shown
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);
        chk_digits("nine settled", 0, 9, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("to10 count", int'(count), 10);
        idle(2);
        chk("to10 mid valid", int'(bcd_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("to11 count", int'(count), 11);
        chk("to11 valid", int'(bcd_valid), 0);
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            nvec++;
            if (bcd_tens == 4'd1 && bcd_ones == 4'd0) begin
                nmiss++;
                $display("FAIL restart edge+%0d: digits 1/0 exposed", n);
            end
            if (n < 8) chk($sformatf("restart valid edge+%0d", n), int'(bcd_valid), 0);
        end
        chk_digits("restart final", 1, 1, 1);

        // Reset mid-conversion at count 42
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (42) step(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        chk("42 count", int'(count), 42);
        chk("42 busy", int'(bcd_valid), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst count", int'(count), 0);
        chk("midrst free",  int'(free), 99);
        chk("midrst empty", int'(empty), 1);
        chk_digits("midrst", 0, 0, 1);
        idle(2);
        chk_digits("midrst hold", 0, 0, 1);

        // Fill to capacity, overflow, digits 9/9, clear
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (99) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("cap count", int'(count), 99);
        chk("cap full",  int'(full), 1);
        chk("cap free",  int'(free), 0);
        chk("cap ovf",   int'(ovf_err), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf count", int'(count), 99);
        chk("ovf flag",  int'(ovf_err), 1);
        idle(9);
        chk_digits("cap digits", 9, 9, 1);
        chk("ovf sticky", int'(ovf_err), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovf clr", int'(ovf_err), 0);
        chk("ovf clr count", int'(count), 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
